// File: rtl/subexpr_if.sv
// Streaming handshake bundle for subexpr_pipe: operand set in, six results out.
// The block is the slave side; the producer/consumer environment is the master side.
interface subexpr_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] x, y, z, p, q, r, s, t;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] o1, o2, o3, o4, o5, o6;

   modport master (
      output in_valid, x, y, z, p, q, r, s, t, out_ready,
      input  in_ready, out_valid, o1, o2, o3, o4, o5, o6
   );

   modport slave (
      input  in_valid, x, y, z, p, q, r, s, t, out_ready,
      output in_ready, out_valid, o1, o2, o3, o4, o5, o6
   );
endinterface

// File: rtl/subexpr_pipe.sv
// Two-stage shared-subexpression arithmetic pipeline with valid/ready on both sides.
// Optional feature macro SUBEXPR_PERF_EN adds the perf_cnt completed-transfer counter.
module subexpr_pipe #(
   parameter int W     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   subexpr_if.slave         bus
`ifdef SUBEXPR_PERF_EN
   ,
   output logic [CNT_W-1:0] perf_cnt
`endif
);

   if (W < 1 || CNT_W < 1) begin : g_bad_param
      $error("subexpr_pipe: W and CNT_W must be positive");
   end

   logic         s1_valid, s2_valid;
   logic         s1_adv, s2_adv;
   logic [W-1:0] xy, pz, qr, xpy, st, px, rpx, q_d, p_d;

   // A stage may advance when it is empty or its successor is advancing too.
   always_comb begin
      s2_adv = !s2_valid || bus.out_ready;
      s1_adv = !s1_valid || s2_adv;
   end

   assign bus.in_ready  = s1_adv;
   assign bus.out_valid = s2_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s2_adv) s2_valid <= s1_valid;
         if (s1_adv) s1_valid <= bus.in_valid;
      end
   end

   // NOTE: stage-1 data carries no reset; it is only ever observed behind s1_valid.
   always_ff @(posedge clk) begin
      if (s1_adv && bus.in_valid) begin
         xy  <= bus.x * bus.y;
         pz  <= bus.p + bus.z;
         qr  <= bus.q - bus.r;
         xpy <= bus.x + bus.y;
         st  <= bus.s + bus.t;
         px  <= bus.p + bus.x;
         rpx <= bus.r + bus.p + bus.x;
         q_d <= bus.q;
         p_d <= bus.p;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.o1 <= '0;
         bus.o2 <= '0;
         bus.o3 <= '0;
         bus.o4 <= '0;
         bus.o5 <= '0;
         bus.o6 <= '0;
      end else if (s2_adv && s1_valid) begin
         bus.o1 <= xy + pz;
         bus.o2 <= pz * qr;
         bus.o3 <= xpy + st;
         bus.o4 <= (xy + q_d) * px;
         bus.o5 <= xy + p_d - rpx;
         bus.o6 <= (xpy + p_d) * qr;
      end
   end

`ifdef SUBEXPR_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           perf_cnt <= '0;
      else if (bus.out_valid && bus.out_ready) perf_cnt <= perf_cnt + CNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_subexpr_pipe.sv
// Self-checking bench for subexpr_pipe: directed steps plus random traffic scored
// against a queue-based reference model evaluated straight from the result formulas.
module tb_subexpr_pipe;

   typedef logic [7:0][31:0] ops_t;   // x,y,z,p,q,r,s,t at indices 0..7
   typedef logic [5:0][31:0] res_t;   // o1..o6 at indices 0..5

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   subexpr_if #(.W(32)) b32 ();
   subexpr_if #(.W(8))  b8 ();

`ifdef SUBEXPR_PERF_EN
   logic [3:0]  perf_cnt;
   logic [15:0] perf_cnt8;
`endif

   subexpr_pipe #(.W(32), .CNT_W(4)) dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b32)
`ifdef SUBEXPR_PERF_EN
      ,
      .perf_cnt (perf_cnt)
`endif
   );

   subexpr_pipe #(.W(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b8)
`ifdef SUBEXPR_PERF_EN
      ,
      .perf_cnt (perf_cnt8)
`endif
   );

   int checks   = 0;
   int failures = 0;
   int n_emit   = 0;
   res_t exp_q[$];
   int   age_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: each result straight from the operands, reduced mod 2^w.
   function automatic res_t model(input ops_t o, input int w);
      longint unsigned m, x, y, z, p, q, r, s, t;
      res_t res;
      m = (64'd1 << w) - 64'd1;
      x = o[0] & m; y = o[1] & m; z = o[2] & m; p = o[3] & m;
      q = o[4] & m; r = o[5] & m; s = o[6] & m; t = o[7] & m;
      res[0] = 32'((x * y + p + z) & m);
      res[1] = 32'(((p + z) * (q - r)) & m);
      res[2] = 32'((x + y + s + t) & m);
      res[3] = 32'(((x * y + q) * (p + x)) & m);
      res[4] = 32'((x * y + p - (r + p + x)) & m);
      res[5] = 32'(((x + y + p) * (q - r)) & m);
      return res;
   endfunction

   function automatic ops_t rand_ops();
      ops_t o;
      for (int i = 0; i < 8; i++) o[i] = $urandom();
      return o;
   endfunction

   task automatic drive32(input logic v, input ops_t o);
      b32.in_valid = v;
      b32.x = o[0]; b32.y = o[1]; b32.z = o[2]; b32.p = o[3];
      b32.q = o[4]; b32.r = o[5]; b32.s = o[6]; b32.t = o[7];
   endtask

   task automatic drive8(input logic v, input ops_t o);
      b8.in_valid = v;
      b8.x = 8'(o[0]); b8.y = 8'(o[1]); b8.z = 8'(o[2]); b8.p = 8'(o[3]);
      b8.q = 8'(o[4]); b8.r = 8'(o[5]); b8.s = 8'(o[6]); b8.t = 8'(o[7]);
   endtask

   // One clock of the 32-bit DUT, entered and left at a falling edge with inputs set.
   task automatic cyc(output bit acc);
      bit   emit, ov_exp, ir_exp;
      res_t d;
      ops_t o;
      #1;
      o = {b32.t, b32.s, b32.r, b32.q, b32.p, b32.z, b32.y, b32.x};
      ir_exp = !(exp_q.size() == 2 && !b32.out_ready);
      ov_exp = exp_q.size() > 0 && age_q[0] >= 2;
      chk("in_ready", 64'(b32.in_ready), 64'(ir_exp));
      chk("out_valid", 64'(b32.out_valid), 64'(ov_exp));
      if (ov_exp) begin
         d[0] = b32.o1; d[1] = b32.o2; d[2] = b32.o3;
         d[3] = b32.o4; d[4] = b32.o5; d[5] = b32.o6;
         for (int i = 0; i < 6; i++)
            chk($sformatf("o%0d", i + 1), 64'(d[i]), 64'(exp_q[0][i]));
      end
`ifdef SUBEXPR_PERF_EN
      chk("perf_cnt", 64'(perf_cnt), 64'(n_emit % 16));
`endif
      acc  = b32.in_valid && ir_exp;
      emit = ov_exp && b32.out_ready;
      @(posedge clk);
      if (emit) begin
         void'(exp_q.pop_front());
         void'(age_q.pop_front());
         n_emit++;
      end
      foreach (age_q[i]) age_q[i]++;
      if (acc) begin
         exp_q.push_back(model(o, 32));
         age_q.push_back(1);
      end
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ops_t o, o8;
      res_t r8;
      bit   acc;
      int   k, base, bound;
      ops_t sets[4];

      rst_n = 1'b0;
      drive32(1'b0, '0);
      drive8(1'b0, '0);
      b32.out_ready = 1'b1;
      b8.out_ready  = 1'b1;
      @(negedge clk);

      // Reset state of both widths.
      chk("rst out_valid", 64'(b32.out_valid), 64'd0);
      chk("rst in_ready", 64'(b32.in_ready), 64'd1);
      chk("rst o1", 64'(b32.o1), 64'd0);
      chk("rst o6", 64'(b32.o6), 64'd0);
      chk("rst8 out_valid", 64'(b8.out_valid), 64'd0);
      chk("rst8 o3", 64'(b8.o3), 64'd0);
`ifdef SUBEXPR_PERF_EN
      chk("rst perf_cnt", 64'(perf_cnt), 64'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Basic directed set with fixed expected values.
      o = {32'd8, 32'd7, 32'd2, 32'd10, 32'd6, 32'd5, 32'd4, 32'd3};
      drive32(1'b1, o);
      cyc(acc);
      drive32(1'b0, '0);
      cyc(acc);
      chk("basic out_valid", 64'(b32.out_valid), 64'd1);
      chk("basic o1", 64'(b32.o1), 64'd23);
      chk("basic o2", 64'(b32.o2), 64'd88);
      chk("basic o3", 64'(b32.o3), 64'd22);
      chk("basic o4", 64'(b32.o4), 64'd198);
      chk("basic o5", 64'(b32.o5), 64'd7);
      chk("basic o6", 64'(b32.o6), 64'd104);
      cyc(acc);

      // Wrap behaviour on the 8-bit instance.
      o8 = {32'd1, 32'd255, 32'd2, 32'd1, 32'd0, 32'd0, 32'd16, 32'd16};
      r8 = model(o8, 8);
      drive8(1'b1, o8);
      @(posedge clk); @(negedge clk);
      drive8(1'b0, '0);
      #1 chk("w8 fill out_valid", 64'(b8.out_valid), 64'd0);
      @(posedge clk); @(negedge clk);
      #1;
      chk("w8 out_valid", 64'(b8.out_valid), 64'd1);
      chk("w8 o1", 64'(b8.o1), 64'(r8[0][7:0]));
      chk("w8 o2", 64'(b8.o2), 64'(r8[1][7:0]));
      chk("w8 o3", 64'(b8.o3), 64'(r8[2][7:0]));
      chk("w8 o4", 64'(b8.o4), 64'(r8[3][7:0]));
      chk("w8 o5", 64'(b8.o5), 64'(r8[4][7:0]));
      chk("w8 o6", 64'(b8.o6), 64'(r8[5][7:0]));
      @(posedge clk); @(negedge clk);
      #1 chk("w8 drained", 64'(b8.out_valid), 64'd0);
      @(negedge clk);

      // Backpressure: four queued sets against a stalled consumer, then drain.
      for (int i = 0; i < 4; i++) sets[i] = rand_ops();
      base = n_emit;
      k = 0;
      b32.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         drive32(k < 4, (k < 4) ? sets[k] : '0);
         cyc(acc);
         if (acc) k++;
      end
      chk("bp accepted while stalled", 64'(k), 64'd2);
      b32.out_ready = 1'b1;
      bound = 0;
      while ((k < 4 || exp_q.size() > 0) && bound < 20) begin
         drive32(k < 4, (k < 4) ? sets[k] : '0);
         cyc(acc);
         if (acc) k++;
         bound++;
      end
      chk("bp drain in bound", 64'(bound < 20), 64'd1);
      chk("bp emitted count", 64'(n_emit - base), 64'd4);

      // Full-rate streaming.
      base = n_emit;
      for (int c = 0; c < 100; c++) begin
         drive32(1'b1, rand_ops());
         cyc(acc);
      end
      drive32(1'b0, '0);
      for (int c = 0; c < 3; c++) cyc(acc);
      chk("stream emitted count", 64'(n_emit - base), 64'd100);

      // Random valid/ready traffic.
      for (int c = 0; c < 200; c++) begin
         drive32(1'($urandom_range(0, 1)), rand_ops());
         b32.out_ready = 1'($urandom_range(0, 3) != 0);
         cyc(acc);
      end
      b32.out_ready = 1'b1;
      drive32(1'b0, '0);
      for (int c = 0; c < 3; c++) cyc(acc);
      chk("random drained", 64'(exp_q.size()), 64'd0);

      // Reset while both stages hold data.
      b32.out_ready = 1'b0;
      drive32(1'b1, rand_ops());
      cyc(acc);
      drive32(1'b1, rand_ops());
      cyc(acc);
      drive32(1'b0, '0);
      cyc(acc);
      chk("pre-reset occupancy", 64'(exp_q.size()), 64'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst out_valid", 64'(b32.out_valid), 64'd0);
      chk("async rst o1", 64'(b32.o1), 64'd0);
      chk("async rst o4", 64'(b32.o4), 64'd0);
      chk("async rst in_ready", 64'(b32.in_ready), 64'd1);
      exp_q.delete();
      age_q.delete();
      n_emit = 0;
      @(negedge clk);
      rst_n = 1'b1;
      b32.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) cyc(acc);

`ifdef SUBEXPR_PERF_EN
      // Counter wrap: 18 transfers leave a 4-bit count at 2.
      for (int c = 0; c < 18; c++) begin
         drive32(1'b1, rand_ops());
         cyc(acc);
      end
      drive32(1'b0, '0);
      cyc(acc);
      cyc(acc);
      chk("perf 18 transfers", 64'(perf_cnt), 64'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
